reg_input_loader: RTL

Byte-serial loader that assembles a register-file test vector (write data plus NUM_ADDR register addresses) from a narrow switch bus and a manual load button. It is the synchronous, parametrised successor of the board-level input demultiplexer. All fields are held in clk-domain registers. The button is synchronised and edge-detected. Each field is tracked as written or not, and the block reports when a full frame is loaded. An auto-increment mode walks the fields without using the select input. It sits between board switches/buttons and the register file under test.

---
 rtl/reg_loader_pkg.sv | 21 ++
 rtl/reg_input_loader_btn_edge_sync.sv | 68 ++++++
 rtl/reg_input_loader.sv | 117 +++++++++++
 3 files changed

// File: rtl/reg_loader_pkg.sv
// Shared constants and elaboration helpers for the register-file input loader.
// Field indices: bytes 0..NB-1 first, then address fields at NB+k.
package reg_loader_pkg;

  localparam int FIELD_BYTE0 = 0;
  // Address-field offset is relative to NB, the number of data bytes.
  localparam int FIELD_ADDR0 = 0;

  function automatic int sel_width(input int num_fields);
    return $clog2(num_fields + 1);
  endfunction

  function automatic bit data_w_ok(input int data_w, input int byte_w);
    return (byte_w > 0) && (data_w >= byte_w) && (data_w % byte_w == 0);
  endfunction

  function automatic bit addr_w_ok(input int addr_w, input int byte_w);
    return (addr_w > 0) && (addr_w <= byte_w);
  endfunction

endpackage

// File: rtl/reg_input_loader_btn_edge_sync.sv
// Button synchroniser with optional debounce (LOADER_DEBOUNCE_EN) and a
// one-cycle pulse on each rising edge of the filtered level.
module btn_edge_sync #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be at least 1");
  end

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchroniser stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= level;
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised level agrees with db_q restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = db_q;
`else
  assign level = sync_q[1];
`endif

  assign pulse_o = level & ~prev_q;

endmodule

// File: rtl/reg_input_loader.sv
// Byte-serial loader assembling write data plus NUM_ADDR register addresses
// from switches and a load button; LOADER_DEBOUNCE_EN adds button debounce.
module reg_input_loader
  import reg_loader_pkg::*;
#(
  parameter  int DATA_W       = 32,
  parameter  int BYTE_W       = 8,
  parameter  int ADDR_W       = 5,
  parameter  int NUM_ADDR     = 3,
  parameter  int DEBOUNCE_CYC = 16,
  localparam int NB           = DATA_W / BYTE_W,
  localparam int F            = NB + NUM_ADDR,
  localparam int SEL_W        = sel_width(F)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL_W-1:0]           sel,
  input  logic [BYTE_W-1:0]          data_in,
  input  logic                       load_btn,
  input  logic                       auto_en,
  input  logic                       clear,
  output logic [DATA_W-1:0]          wd3,
  output logic [NUM_ADDR*ADDR_W-1:0] addr_out,
  output logic [SEL_W-1:0]           ptr,
  output logic [F-1:0]               written,
  output logic                       frame_valid,
  output logic                       load_ack,
  output logic                       load_err
);

  if (!data_w_ok(DATA_W, BYTE_W)) begin : g_bad_data_w
    $error("DATA_W must be a non-zero multiple of BYTE_W");
  end
  if (!addr_w_ok(ADDR_W, BYTE_W)) begin : g_bad_addr_w
    $error("ADDR_W must be between 1 and BYTE_W");
  end

  logic                       load_evt;
  logic [SEL_W-1:0]           target;
  logic [DATA_W-1:0]          wd3_q, wd3_d;
  logic [NUM_ADDR*ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]           ptr_q, ptr_d;
  logic [F-1:0]               written_q, written_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;

  btn_edge_sync #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_load_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (load_btn),
    .pulse_o(load_evt)
  );

  assign target = auto_en ? ptr_q : sel;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wd3_d     = wd3_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    written_d = written_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    if (clear) begin
      written_d = '0;
      ptr_d     = '0;
    end else if (load_evt) begin
      if (int'(target) >= F) begin
        err_d = 1'b1;
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (int'(target) == FIELD_BYTE0 + b) wd3_d[b*BYTE_W +: BYTE_W] = data_in;
        end
        for (int k = 0; k < NUM_ADDR; k++) begin
          if (int'(target) == NB + FIELD_ADDR0 + k) addr_d[k*ADDR_W +: ADDR_W] = data_in[ADDR_W-1:0];
        end
        for (int i = 0; i < F; i++) begin
          if (int'(target) == i) written_d[i] = 1'b1;
        end
        ack_d = 1'b1;
        if (auto_en) ptr_d = (int'(ptr_q) == F - 1) ? '0 : ptr_q + SEL_W'(1);
      end
    end
  end

  // NOTE: the data and address fields are a handful of flops, not a RAM, and
  // the register file under test must see known values, so they are reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd3_q     <= '0;
      addr_q    <= '0;
      ptr_q     <= '0;
      written_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wd3_q     <= wd3_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      written_q <= written_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign wd3         = wd3_q;
  assign addr_out    = addr_q;
  assign ptr         = ptr_q;
  assign written     = written_q;
  assign frame_valid = &written_q;
  assign load_ack    = ack_q;
  assign load_err    = err_q;

endmodule
